// File: rtl/fetch_prefetch_queue_if.sv
// Purpose : fetch-to-decode bundle: redirect in, instruction-memory port, decode handshake, occupancy.
// Latency : wires only; timing is set by the queue that drives the slave side.
// Backpr. : decodeValid/decodeReady handshake; fetchRequest low when the queue cannot accept.
// Ports   : redirectValid/redirectPc, fetchAddress/fetchRequest/fetchInstruction,
//           decodeValid/decodeReady/decodePc/decodeInstruction, occupancy.
interface fetch_prefetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                       redirectValid;
  logic [XLEN-1:0]            redirectPc;
  logic [XLEN-1:0]            fetchAddress;
  logic                       fetchRequest;
  logic [XLEN-1:0]            fetchInstruction;
  logic                       decodeValid;
  logic                       decodeReady;
  logic [XLEN-1:0]            decodePc;
  logic [XLEN-1:0]            decodeInstruction;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  // Environment side: memory stage, instruction memory and decode.
  modport master (
    output redirectValid, redirectPc, fetchInstruction, decodeReady,
    input  fetchAddress, fetchRequest, decodeValid, decodePc, decodeInstruction, occupancy
  );

  // Queue side.
  modport slave (
    input  redirectValid, redirectPc, fetchInstruction, decodeReady,
    output fetchAddress, fetchRequest, decodeValid, decodePc, decodeInstruction, occupancy
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Purpose : fetch PC owner + DEPTH-entry {pc, instr} circular queue feeding decode.
// Latency : 1 cycle fetch-to-decode; 0 when queue empty and PREFETCH_BYPASS_EN is defined.
// Backpr. : decodeReady low stalls pops; fetching stops when full unless a pop frees a slot.
// Ports   : clock, reset (async, active-high), bus (fetch_prefetch_queue_if.slave).
// Option  : `define PREFETCH_BYPASS_EN to forward the fetched pair straight to decode when empty.
module fetch_prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input logic                   clock,
  input logic                   reset,
  fetch_prefetch_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Storage is not reset; count_q alone says which entries are live.
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] ins_mem [DEPTH];

  logic head_vld;
  logic pop_head;
  logic full;
  logic fetch_req;
  logic bypass;
  logic byp_take;
  logic push_wr;

  // Low address bits of a redirect target are forced to zero.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirectPc[1:0];

  assign head_vld = (count_q != '0);
  assign full     = (count_q == CW'(DEPTH));
  // A pop from the stored head; redirect suppresses it even with decodeReady high.
  assign pop_head = head_vld && bus.decodeReady && !bus.redirectValid;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign fetch_req = (!full || pop_head) && !bus.redirectValid;

`ifdef PREFETCH_BYPASS_EN
  // Empty queue: present the memory data directly; if taken, it never gets written.
  assign bypass   = fetch_req && !head_vld;
  assign byp_take = bypass && bus.decodeReady;
`else
  assign bypass   = 1'b0;
  assign byp_take = 1'b0;
`endif

  assign push_wr = fetch_req && !byp_take;

  always_comb begin
    bus.decodeValid       = head_vld || bypass;
    bus.decodePc          = '0;
    bus.decodeInstruction = '0;
    if (head_vld) begin
      bus.decodePc          = pc_mem[rd_ptr_q];
      bus.decodeInstruction = ins_mem[rd_ptr_q];
    end else if (bypass) begin
      bus.decodePc          = pc_q;
      bus.decodeInstruction = bus.fetchInstruction;
    end
  end

  assign bus.fetchAddress = pc_q;
  assign bus.fetchRequest = fetch_req;
  assign bus.occupancy    = count_q;

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirectValid) begin
      pc_d     = {bus.redirectPc[XLEN-1:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fetch_req) pc_d     = pc_q + XLEN'(4);
      if (push_wr)   wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_head)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_wr, pop_head})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q     <= PC_RESET;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_wr) begin
      pc_mem[wr_ptr_q]  <= pc_q;
      ins_mem[wr_ptr_q] <= bus.fetchInstruction;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Purpose : directed self-checking bench for fetch_prefetch_queue (DEPTH = 4).
// Latency : expectations follow the build: 1-cycle fetch-to-decode, 0 with PREFETCH_BYPASS_EN.
// Backpr. : bench drives decodeReady directly, including random toggling in the wrap phase.
module tb_fetch_prefetch_queue;
  localparam int          XLEN = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] XORK = 32'hA5A5_0000;
`ifdef PREFETCH_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          accepted;
  logic [31:0] exp_pc;

  fetch_prefetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  // Instruction memory model: data is a fixed function of the address.
  assign bus.fetchInstruction = bus.fetchAddress ^ XORK;

  fetch_prefetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .PC_RESET(32'h0000_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    reset = 1'b1;
    bus.redirectValid = 1'b0;
    bus.redirectPc = '0;
    bus.decodeReady = ready;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.redirectValid = 1'b0;
    bus.redirectPc    = '0;
    bus.decodeReady   = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state
    check("rst_dvalid", 32'(bus.decodeValid), 32'd0);
    check("rst_dpc", bus.decodePc, 32'd0);
    check("rst_dins", bus.decodeInstruction, 32'd0);
    check("rst_occ", 32'(bus.occupancy), 32'd0);
    check("rst_faddr", bus.fetchAddress, 32'd0);

    // Streaming with decode always ready
    reset = 1'b0;
    bus.decodeReady = 1'b1;
    #1;
    check("t1_faddr0", bus.fetchAddress, 32'd0);
    check("t1_freq0", 32'(bus.fetchRequest), 32'd1);
    check("t1_dvalid0", 32'(bus.decodeValid), 32'(LAT == 0));
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("t1_faddr", bus.fetchAddress, 32'(4 * k));
      check("t1_dvalid", 32'(bus.decodeValid), 32'd1);
      check("t1_dpc", bus.decodePc, 32'(4 * (k - LAT)));
      check("t1_dins", bus.decodeInstruction, 32'(4 * (k - LAT)) ^ XORK);
      check("t1_occ", 32'(bus.occupancy), 32'(LAT));
    end

    // Decode stalled: queue fills to DEPTH, then fetching stops
    do_reset(1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t2_occ", 32'(bus.occupancy), 32'((k < DEPTH) ? k : DEPTH));
      check("t2_faddr", bus.fetchAddress, 32'(4 * ((k < DEPTH) ? k : DEPTH)));
      check("t2_freq", 32'(bus.fetchRequest), 32'(k < DEPTH));
      check("t2_dpc", bus.decodePc, 32'd0);
    end

    // Full queue with one pop: push and pop share the edge
    bus.decodeReady = 1'b1;
    #1;
    check("t3_freq_full_pop", 32'(bus.fetchRequest), 32'd1);
    tick();
    bus.decodeReady = 1'b0;
    #1;
    check("t3_occ", 32'(bus.occupancy), 32'd4);
    check("t3_dpc", bus.decodePc, 32'd4);
    check("t3_dins", bus.decodeInstruction, 32'd4 ^ XORK);
    check("t3_faddr", bus.fetchAddress, 32'd20);
    tick();
    check("t3_hold_dpc", bus.decodePc, 32'd4);

    // Redirect with three entries queued and decode ready
    do_reset(1'b0);
    repeat (3) tick();
    check("t4_occ3", 32'(bus.occupancy), 32'd3);
    check("t4_faddr12", bus.fetchAddress, 32'd12);
    bus.redirectValid = 1'b1;
    bus.redirectPc    = 32'h0000_0103;
    bus.decodeReady   = 1'b1;
    #1;
    check("t4_freq_redir", 32'(bus.fetchRequest), 32'd0);
    check("t4_dpc_redir", bus.decodePc, 32'd0);
    tick();
    bus.redirectValid = 1'b0;
    #1;
    check("t4_occ0", 32'(bus.occupancy), 32'd0);
    check("t4_faddr", bus.fetchAddress, 32'h0000_0100);
    check("t4_dvalid_gap", 32'(bus.decodeValid), 32'(LAT == 0));
    tick();
    exp_pc = 32'h0000_0100 + 32'(4 * (1 - LAT));
    check("t4_dvalid", 32'(bus.decodeValid), 32'd1);
    check("t4_dpc", bus.decodePc, exp_pc);
    check("t4_dins", bus.decodeInstruction, exp_pc ^ XORK);

    // Pointer wrap with random decodeReady: decode sees consecutive PCs
    accepted = 0;
    for (int i = 0; i < 80; i++) begin
      bus.decodeReady = 1'($urandom_range(0, 1));
      #1;
      check("t5_dvalid", 32'(bus.decodeValid), 32'd1);
      check("t5_occ_bound", 32'(bus.occupancy <= 3'(DEPTH)), 32'd1);
      if (bus.decodeValid && bus.decodeReady) begin
        check("t5_dpc", bus.decodePc, exp_pc);
        check("t5_dins", bus.decodeInstruction, exp_pc ^ XORK);
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      tick();
    end
    check("t5_wrap_count", 32'(accepted >= 3 * DEPTH), 32'd1);

    // Asynchronous reset in the middle of a cycle
    do_reset(1'b0);
    tick();
    tick();
    check("t6_occ2", 32'(bus.occupancy), 32'd2);
    #3;
    reset = 1'b1;
    #1;
    check("t6_dvalid", 32'(bus.decodeValid), 32'd0);
    check("t6_occ", 32'(bus.occupancy), 32'd0);
    check("t6_faddr", bus.fetchAddress, 32'd0);
    check("t6_dpc", bus.decodePc, 32'd0);
    #2;
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
